// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-address generator.
// The mask helper is also meant for the BTB.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StPend
    } pc_state_e;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam int unsigned MAX_FETCH_N       = 4;
    localparam logic [63:0] DEFAULT_RESET_VEC = 64'h8000_0000;

    // Slot i is live when it exists in an n-wide group and sits at or after the entry offset.
    function automatic logic [MAX_FETCH_N-1:0] fetch_mask(input int unsigned n,
                                                          input logic [1:0] offset);
        logic [MAX_FETCH_N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_FETCH_N; i++) begin
            m[i] = (i < n) && (i >= 32'(offset));
        end
        return m;
    endfunction

endpackage

// File: rtl/pc_fetch_mask.sv
// Combinational decoder from the in-group word offset to the per-slot valid mask.
module pc_fetch_mask
    import pc_gen_pkg::*;
#(
    parameter int unsigned FETCH_N = 1,
    localparam int unsigned OFF_W  = (FETCH_N > 1) ? $clog2(FETCH_N) : 1
) (
    input  logic [OFF_W-1:0]   offset,
    output logic [FETCH_N-1:0] mask
);

    logic [MAX_FETCH_N-1:0] full;
    logic                   unused_full;

    always_comb begin
        full = fetch_mask(FETCH_N, 2'(offset));
        mask = full[FETCH_N-1:0];
    end

    assign unused_full = ^full;

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: valid/ready request port to the I-cache with trap/branch redirects
// and a pending-redirect buffer for redirects that arrive while a request is unaccepted.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       FETCH_N   = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trap_valid,
    input  logic [ADDR_W-1:0]  trap_addr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               stall,
    output logic               fetch_valid,
    output logic [ADDR_W-1:0]  fetch_addr,
    output logic [FETCH_N-1:0] fetch_mask,
    input  logic               fetch_ready,
    output logic               fetch_kill,
    output logic [ADDR_W-1:0]  pc_out
);

    localparam int unsigned       OFF_W = (FETCH_N > 1) ? $clog2(FETCH_N) : 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(FETCH_N * INSTR_BYTES);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              outstanding_q, outstanding_d;
    logic              kill_q, kill_d;
    logic              redir, accept;
    logic [ADDR_W-1:0] target;
    logic [OFF_W-1:0]  offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            addr_q        <= RESET_VEC;
            pend_q        <= '0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            pend_q        <= pend_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    always_comb begin
        redir         = trap_valid | redirect_valid;
        target        = trap_valid ? trap_addr : redirect_addr;
        target[1:0]   = 2'b00;
        state_d       = state_q;
        addr_d        = addr_q;
        pend_d        = pend_q;
        kill_d        = 1'b0;
        outstanding_d = fetch_valid && !fetch_ready;
        unique case (state_q)
            StBoot: begin
                state_d = StRun;
                if (redir) addr_d = target;
            end
            StRun: begin
                if (redir) begin
                    // An unaccepted request must keep its address; park the target instead.
                    if (fetch_valid && !fetch_ready) begin
                        pend_d  = target;
                        state_d = StPend;
                    end else begin
                        addr_d = target;
                    end
                end else if (accept) begin
                    addr_d = (addr_q & ~(STEP - 1'b1)) + STEP;
                end
            end
            StPend: begin
                if (redir) pend_d = target;
                if (accept) begin
                    addr_d  = pend_d;
                    kill_d  = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        fetch_valid = (state_q != StBoot) && !(stall && !outstanding_q);
        accept      = fetch_valid && fetch_ready;
        fetch_addr  = addr_q;
        pc_out      = addr_q;
        fetch_kill  = kill_q;
    end

    if (FETCH_N > 1) begin : g_offset
        assign offset = addr_q[OFF_W+1:2];
    end else begin : g_offset_single
        assign offset = '0;
    end

    pc_fetch_mask #(
        .FETCH_N (FETCH_N)
    ) u_fetch_mask (
        .offset (offset),
        .mask   (fetch_mask)
    );

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the Balotelli front end. It replaces the single-width PC register with the following:
- a valid/ready request port to the instruction cache;
- a configurable fetch-group width;
- trap and branch redirects with fixed priority;
- a pending-redirect buffer so a redirect arriving during an unaccepted request is never lost.

It sits between Ctrl/Clint and the I-cache, ahead of If2Id.

## Interface
- ADDR_W, 64, address width in bits
- FETCH_N, 1, instructions per fetch group; legal values 1, 2, 4
- RESET_VEC, 64'h8000_0000, first fetch address; must be aligned to FETCH_N*4 bytes
- Clk  input  1  clock
- Rst  input  1  asynchronous, active-low reset
- TrapValid  input  1  trap/interrupt redirect from Clint; highest priority
- TrapAddr  input  ADDR_W  trap target
- RedirectValid  input  1  branch/jump redirect from Ctrl
- RedirectAddr  input  ADDR_W  redirect target
- Stall  input  1  pipeline hold from Ctrl; suppresses new requests only
- FetchValid  output  1  request valid
- FetchAddr  output  ADDR_W  request address; bits [1:0] always 0
- FetchMask  output  FETCH_N  per-slot valid mask for the group
- FetchReady  input  1  cache accepts the request this cycle
- FetchKill  output  1  one-cycle pulse: discard the response of the request accepted in the previous cycle
- PcOut  output  ADDR_W  equals FetchAddr

## Operation
- States:
  - BOOT: after reset only.
  - RUN: normal operation.
  - PEND: a redirect is held while the current request is unaccepted.
- Outstanding register: set when FetchValid && !FetchReady; cleared on accept.
- FetchValid = (state != BOOT) && !(Stall && !Outstanding). Once asserted, FetchValid and FetchAddr stay stable until FetchReady.
- Priority when both redirects are valid: TrapValid beats RedirectValid. Bits [1:0] of the winning target are forced to 0.
- RUN, redirect, no outstanding request: FetchAddr = target next cycle; stay in RUN.
- RUN, redirect, request unaccepted this cycle: latch the target into PendAddr; go to PEND. FetchAddr is unchanged.
- PEND:
  - A new redirect overwrites PendAddr; trap priority still applies.
  - On FetchReady: FetchAddr = PendAddr and FetchKill = 1 next cycle; return to RUN.
- Sequential advance, in RUN on accept with no redirect: FetchAddr = (FetchAddr & ~(FETCH_N*4-1)) + FETCH_N*4.
  - Arithmetic is modulo 2^ADDR_W, so address all-ones wraps to 0.
- FetchMask[i] = 1 iff i >= FetchAddr[log2(FETCH_N)+1:2]. For FETCH_N=1 this is the constant 1.
- Stall with no outstanding request: FetchAddr holds, and redirects are still applied directly (state stays RUN).

## Timing
- Reset values:
  - state = BOOT
  - FetchAddr = PcOut = RESET_VEC
  - FetchValid = 0
  - FetchKill = 0
  - Outstanding = 0
  - PendAddr = 0
  - FetchMask = all ones
- BOOT lasts exactly one cycle after Rst deasserts. FetchValid rises in the second cycle.
- Redirect-to-request latency:
  - 1 cycle if no request is outstanding.
  - Accept cycle + 1 otherwise.
- FetchKill is high for exactly one cycle, the cycle after the accepting FetchReady, and only on exit from PEND.
- Redirect and FetchReady in the same RUN cycle: the accepted request is valid (no kill); the target is applied next cycle.
- Rst asserted mid-operation: all state clears asynchronously, including any pending redirect.

## Structure
- Package pc_gen_pkg contains:
  - state enum {BOOT, RUN, PEND};
  - INSTR_BYTES = 4;
  - default RESET_VEC;
  - function fetch_mask(offset).
- Sub-module pc_fetch_mask: combinational offset→mask decoder, reused later by the BTB.
- Everything else is flat in pc_gen: FSM, Outstanding, PendAddr, address register.

## Test plan
- Reset release, FETCH_N=1, FetchReady=1 constant → FetchValid=0 in the first cycle. The following accepted FetchAddr values are 0x80000000, 0x80000004, 0x80000008. FetchKill never asserts.
- FETCH_N=4, RedirectAddr=0x80000028 → FetchAddr=0x80000028 with FetchMask=4'b1100. The next FetchAddr is 0x80000030 with mask 4'b1111.
- Request at 0x80000010 held with FetchReady=0 for 3 cycles; RedirectAddr=0x80000100 in cycle 1 → FetchAddr stays 0x80000010 until accept. The next FetchAddr is 0x80000100 and FetchKill pulses for one cycle.
- Same cycle TrapValid (0x80000200) and RedirectValid (0x80000300) → next FetchAddr = 0x80000200.
- Stall=1 with no outstanding request → FetchValid=0 and FetchAddr frozen. Stall=1 while a request is unaccepted → FetchValid stays 1 until FetchReady.
- FetchAddr=0xFFFF_FFFF_FFFF_FFFC, FETCH_N=1, accept → next FetchAddr = 0. Rst pulse while in PEND → FetchAddr=RESET_VEC and no kill pulse.
